// File: rtl/lfsr_prbs_checker.sv
// Receive-side checker for the 32-bit XNOR PRBS (taps 31,21,1,0): self-synchronises a local
// LFSR to the incoming serial stream, declares lock, then counts bit errors against it.
module lfsr_prbs_checker #(
   parameter int LOCK_CNT    = 64,
   parameter int WINDOW      = 256,
   parameter int LOSS_THRESH = 16,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             bit_in,
   input  logic             bit_valid,
   input  logic             clear_cnt,
   output logic             locked,
   output logic             err_pulse,
   output logic [CNT_W-1:0] err_count,
   output logic [CNT_W-1:0] bit_count,
   output logic [1:0]       state
);

   typedef enum logic [1:0] {
      ST_SEARCH = 2'd0,
      ST_SYNC   = 2'd1,
      ST_LOCKED = 2'd2
   } state_t;

   localparam int MATCH_W = $clog2(LOCK_CNT + 1);
   localparam int WIN_W   = (WINDOW > 1) ? $clog2(WINDOW) : 1;
   localparam int MISS_W  = $clog2(LOSS_THRESH + 1);

   localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_CNT - 1);
   localparam logic [WIN_W-1:0]   WIN_LAST   = WIN_W'(WINDOW - 1);
   localparam logic [MISS_W-1:0]  MISS_LIMIT = MISS_W'(LOSS_THRESH);

   state_t             state_q, state_d;
   logic [31:0]        r_q, r_d;
   logic [4:0]         fill_q, fill_d;
   logic [MATCH_W-1:0] match_q, match_d;
   logic [WIN_W-1:0]   win_q, win_d;
   logic [MISS_W-1:0]  miss_q, miss_d;
   logic [MISS_W-1:0]  miss_inc;
   logic [CNT_W-1:0]   err_count_q, err_count_d;
   logic [CNT_W-1:0]   bit_count_q, bit_count_d;
   logic               err_pulse_q, err_pulse_d;
   logic               pred;
   logic               mism;

   // Counters stick at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   always_comb begin
      pred        = ~(r_q[31] ^ r_q[21] ^ r_q[1] ^ r_q[0]);
      mism        = bit_in ^ pred;
      miss_inc    = miss_q + {{(MISS_W-1){1'b0}}, mism};
      state_d     = state_q;
      r_d         = r_q;
      fill_d      = fill_q;
      match_d     = match_q;
      win_d       = win_q;
      miss_d      = miss_q;
      err_count_d = err_count_q;
      bit_count_d = bit_count_q;
      err_pulse_d = 1'b0;

      if (bit_valid) begin
         unique case (state_q)
            ST_SEARCH: begin
               r_d    = {r_q[30:0], bit_in};
               fill_d = fill_q + 5'd1;
               if (fill_q == 5'd31) begin
                  state_d = ST_SYNC;
                  match_d = '0;
               end
            end
            ST_SYNC: begin
               r_d = {r_q[30:0], bit_in};
               // All-ones is the XNOR lockup state: it predicts itself forever, so never trust it.
               if (&r_q) begin
                  match_d = '0;
               end else if (!mism) begin
                  if (match_q == MATCH_LAST) begin
                     state_d = ST_LOCKED;
                     match_d = '0;
                     win_d   = '0;
                     miss_d  = '0;
                  end else begin
                     match_d = match_q + 1'b1;
                  end
               end else begin
                  match_d = '0;
               end
            end
            ST_LOCKED: begin
               // Free-running: received errors never enter the register, so one flip is one error.
               r_d         = {r_q[30:0], pred};
               bit_count_d = sat_inc(bit_count_q);
               if (mism) begin
                  err_count_d = sat_inc(err_count_q);
                  err_pulse_d = 1'b1;
               end
               if (win_q == WIN_LAST) begin
                  win_d  = '0;
                  miss_d = '0;
               end else begin
                  win_d  = win_q + 1'b1;
                  miss_d = miss_inc;
               end
               if (miss_inc == MISS_LIMIT) begin
                  state_d = ST_SEARCH;
                  fill_d  = '0;
               end
            end
            default: begin
               state_d = ST_SEARCH;
               fill_d  = '0;
            end
         endcase
      end

      if (clear_cnt) begin
         err_count_d = '0;
         bit_count_d = '0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_SEARCH;
         r_q         <= '0;
         fill_q      <= '0;
         match_q     <= '0;
         win_q       <= '0;
         miss_q      <= '0;
         err_count_q <= '0;
         bit_count_q <= '0;
         err_pulse_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         r_q         <= r_d;
         fill_q      <= fill_d;
         match_q     <= match_d;
         win_q       <= win_d;
         miss_q      <= miss_d;
         err_count_q <= err_count_d;
         bit_count_q <= bit_count_d;
         err_pulse_q <= err_pulse_d;
      end
   end

   always_comb begin
      locked    = (state_q == ST_LOCKED);
      err_pulse = err_pulse_q;
      err_count = err_count_q;
      bit_count = bit_count_q;
      unique case (state_q)
         ST_SYNC:   state = 2'd1;
         ST_LOCKED: state = 2'd2;
         default:   state = 2'd0;
      endcase
   end

endmodule
